// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory responder with optional wait states
// and a two-cycle ERROR response for out-of-range, illegal-size or misaligned transfers.
module ahb_slave_mem #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic               HWRITE,
   input  logic [1:0]         HSIZE,
   input  logic [2:0]         HBURST,
   input  logic signed [31:0] HWDATA,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic               HRESP,
   output logic signed [31:0] HRDATA
);

   localparam int unsigned      IDX_W     = $clog2(DEPTH);
   localparam int unsigned      CNT_W     = 3;
   localparam logic [32:0]      SPAN      = 33'(4 * DEPTH);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [31:0]      addr_q;
   logic [IDX_W-1:0] idx_q;
   logic             write_q;
   logic [1:0]       size_q;
   logic [1:0]       trans_q;
   logic [31:0]      mem [DEPTH];

   logic [32:0]      off;
   logic [IDX_W-1:0] in_idx;
   logic             xfer_valid;
   logic             addr_err;
   logic [3:0]       lane_en;
   logic             commit;
   logic [31:0]      wr_word;
   logic             rd_load;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      rd_word;
   logic             ready_n;
   logic             resp_n;
   logic             unused_bits;

   // Decode the address phase on the bus: word index, validity and error conditions.
   always_comb begin
      off        = {1'b0, HADDR} - {1'b0, BASE_ADDR};
      in_idx     = off[IDX_W+1:2];
      xfer_valid = HREADY && HSEL && HTRANS[1];
      addr_err   = off[32] || (off >= SPAN) || (HSIZE == 2'd3)
                   || ((HSIZE == 2'd1) && HADDR[0])
                   || ((HSIZE == 2'd2) && (HADDR[1:0] != 2'd0));
   end

   // Byte-lane enables of the captured transfer and the merged word it writes.
   always_comb begin
      case (size_q)
         2'd0:    lane_en = 4'b0001 << addr_q[1:0];
         2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
      commit  = (state_q == ST_DATA) && write_q;
      wr_word = mem[idx_q];
      for (int b = 0; b < 4; b++) begin
         if (lane_en[b]) wr_word[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
   end

   // Next state, wait counter, next response and read-data selection.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      rd_load = 1'b0;
      rd_idx  = idx_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_n = ST_DATA;
               cnt_n   = '0;
               rd_load = !write_q;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_ERR1: state_n = ST_ERR2;
         default: begin
            state_n = ST_IDLE;
            if (xfer_valid) begin
               if (addr_err) begin
                  state_n = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_n = ST_DATA;
                  rd_load = !HWRITE;
                  rd_idx  = in_idx;
               end else begin
                  state_n = ST_WAIT;
                  cnt_n   = WAIT_INIT;
               end
            end
         end
      endcase
      ready_n = !((state_n == ST_WAIT) || (state_n == ST_ERR1));
      resp_n  = (state_n == ST_ERR1) || (state_n == ST_ERR2);
      // A write committing on this edge to the word being read is forwarded.
      rd_word = (commit && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];
   end

   // State, captured address phase and registered bus outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         size_q    <= 2'd0;
         trans_q   <= 2'd0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         HREADYOUT <= ready_n;
         HRESP     <= resp_n;
         if (rd_load) HRDATA <= rd_word;
         if (HREADY) begin
            addr_q  <= HADDR;
            idx_q   <= in_idx;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            trans_q <= HTRANS;
         end
      end
   end

   // Memory array write on completion of a write data phase; contents are not reset.
   always_ff @(posedge HCLK) begin
      if (commit) mem[idx_q] <= wr_word;
   end

   assign unused_bits = ^{HBURST, trans_q, addr_q[31:2]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: two slaves (zero-wait and two-wait) on one shared AHB-Lite bus,
// checked cycle by cycle against a transaction-level response and memory model.
module tb_ahb_slave_mem;

   localparam int unsigned DEPTH  = 64;
   localparam logic [1:0]  T_IDLE = 2'd0;
   localparam logic [1:0]  T_BUSY = 2'd1;
   localparam logic [1:0]  T_NSEQ = 2'd2;
   localparam logic [1:0]  T_SEQ  = 2'd3;

   typedef struct packed {
      logic        rdy;
      logic        resp;
      logic [31:0] data;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         hsel;
   logic [31:0]        haddr;
   logic [1:0]         htrans;
   logic               hwrite;
   logic [1:0]         hsize;
   logic [2:0]         hburst;
   logic signed [31:0] hwdata;
   logic               hready;
   logic               rdy0, rdy1, resp0, resp1;
   logic signed [31:0] rdata0, rdata1;

   int   act;
   bit   chk_en;
   int   checks;
   int   errors;
   logic [7:0]  mmem [2][256];
   logic [31:0] last_rd [2];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   assign hready = (act == 0) ? rdy0 : rdy1;

   ahb_slave_mem #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

   ahb_slave_mem #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut1 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mword(input int d, input logic [31:0] a);
      int b;
      b = int'({a[7:2], 2'b00});
      return {mmem[d][b+3], mmem[d][b+2], mmem[d][b+1], mmem[d][b]};
   endfunction

   // Expected data-phase cycles of one captured address phase, plus memory update.
   function automatic void model_push(input int d, input logic sel, input logic [31:0] addr,
                                      input logic [1:0] trans, input logic wr,
                                      input logic [1:0] size, input logic [31:0] wdata);
      int  nb;
      int  waits;
      bit  err;
      waits = (d == 1) ? 2 : 0;
      if (!(sel && trans[1])) begin
         exp_q.push_back('{rdy: 1'b1, resp: 1'b0, data: last_rd[d]});
         return;
      end
      nb  = 1 << size;
      err = (addr >= 32'(4 * DEPTH)) || (size == 2'd3) || ((int'(addr[1:0]) % nb) != 0);
      if (err) begin
         exp_q.push_back('{rdy: 1'b0, resp: 1'b1, data: last_rd[d]});
         exp_q.push_back('{rdy: 1'b1, resp: 1'b1, data: last_rd[d]});
         return;
      end
      for (int w = 0; w < waits; w++) exp_q.push_back('{rdy: 1'b0, resp: 1'b0, data: last_rd[d]});
      if (wr) begin
         for (int i = 0; i < nb; i++) begin
            int a;
            a = int'(addr[7:0]) + i;
            mmem[d][a] = wdata[8*(a%4) +: 8];
         end
      end else begin
         last_rd[d] = mword(d, addr);
      end
      exp_q.push_back('{rdy: 1'b1, resp: 1'b0, data: last_rd[d]});
   endfunction

   // Present one address phase, wait (bounded) for HREADY, let it be captured.
   task automatic beat(input int d, input logic sel, input logic [31:0] addr,
                       input logic [1:0] trans, input logic wr, input logic [1:0] size,
                       input logic [31:0] wdata, output int waited);
      waited = 0;
      hsel   = sel ? ((d == 0) ? 2'b01 : 2'b10) : 2'b00;
      haddr  = addr;
      htrans = trans;
      hwrite = wr;
      hsize  = size;
      while (hready !== 1'b1 && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (hready !== 1'b1) chk("hready_timeout", 32'(hready), 32'h1);
      @(posedge clk);
      model_push(d, sel, addr, trans, wr, size, wdata);
      #1;
      hwdata = wdata;
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
      int w;
      beat(d, 1'b1, a, T_NSEQ, 1'b1, 2'd2, v, w);
   endtask

   task automatic rd(input int d, input logic [31:0] a);
      int w;
      beat(d, 1'b1, a, T_NSEQ, 1'b0, 2'd2, 32'h0, w);
   endtask

   task automatic idle(input int d, output int w);
      beat(d, 1'b0, 32'h0, T_IDLE, 1'b0, 2'd2, 32'h0, w);
   endtask

   // Per-cycle comparison of the active slave against the model; the other slave must idle.
   always @(negedge clk) begin
      exp_t        e;
      logic        ar, as;
      logic [31:0] ad;
      if (rst_n && chk_en) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{rdy: 1'b1, resp: 1'b0, data: last_rd[act]};
         ar = (act == 0) ? rdy0 : rdy1;
         as = (act == 0) ? resp0 : resp1;
         ad = (act == 0) ? rdata0 : rdata1;
         chk("HREADYOUT", 32'(ar), 32'(e.rdy));
         chk("HRESP", 32'(as), 32'(e.resp));
         chk("HRDATA", ad, e.data);
         chk("other_ready", 32'((act == 0) ? rdy1 : rdy0), 32'h1);
         chk("other_resp", 32'((act == 0) ? resp1 : resp0), 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      checks = 0;
      errors = 0;
      act    = 0;
      chk_en = 1'b0;
      hsel   = 2'b00;
      haddr  = 32'h0;
      htrans = T_IDLE;
      hwrite = 1'b0;
      hsize  = 2'd2;
      hburst = 3'd0;
      hwdata = 32'sh0;
      for (int d = 0; d < 2; d++) begin
         last_rd[d] = 32'h0;
         for (int a = 0; a < 256; a++) mmem[d][a] = 8'h00;
      end

      // reset values
      #12;
      chk("rst_ready0", 32'(rdy0), 32'h1);
      chk("rst_resp0", 32'(resp0), 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_ready1", 32'(rdy1), 32'h1);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // word write then back-to-back read of the same word
      wr(0, 32'h10, 32'hDEAD_BEEF);
      rd(0, 32'h10);
      idle(0, w);
      chk("pin_deadbeef", rdata0, 32'hDEAD_BEEF);

      // INCR burst with a BUSY beat, then read back as a burst
      hburst = 3'd1;
      beat(0, 1'b1, 32'h20, T_NSEQ, 1'b1, 2'd2, 32'd1, w);
      beat(0, 1'b1, 32'h24, T_SEQ,  1'b1, 2'd2, 32'd2, w);
      beat(0, 1'b1, 32'h28, T_BUSY, 1'b1, 2'd2, 32'h0, w);
      beat(0, 1'b1, 32'h28, T_SEQ,  1'b1, 2'd2, 32'd3, w);
      beat(0, 1'b1, 32'h2C, T_SEQ,  1'b1, 2'd2, 32'd4, w);
      beat(0, 1'b1, 32'h20, T_NSEQ, 1'b0, 2'd2, 32'h0, w);
      beat(0, 1'b1, 32'h24, T_SEQ,  1'b0, 2'd2, 32'h0, w);
      beat(0, 1'b1, 32'h28, T_SEQ,  1'b0, 2'd2, 32'h0, w);
      beat(0, 1'b1, 32'h2C, T_SEQ,  1'b0, 2'd2, 32'h0, w);
      hburst = 3'd0;
      idle(0, w);
      chk("pin_burst_last", rdata0, 32'd4);
      chk("model_0x28", mword(0, 32'h28), 32'd3);

      // byte and halfword writes merged into one word
      wr(0, 32'h40, 32'h0);
      beat(0, 1'b1, 32'h41, T_NSEQ, 1'b1, 2'd0, 32'h0000_AA00, w);
      beat(0, 1'b1, 32'h42, T_NSEQ, 1'b1, 2'd1, 32'h1234_0000, w);
      rd(0, 32'h40);
      idle(0, w);
      chk("pin_lanes", rdata0, 32'h1234_AA00);
      chk("model_0x40", mword(0, 32'h40), 32'h1234_AA00);

      // ERROR responses: out of range, misaligned word write, illegal size
      wr(0, 32'h0, 32'hCAFE_F00D);
      rd(0, 32'h100);
      beat(0, 1'b1, 32'h02, T_NSEQ, 1'b1, 2'd2, 32'hFFFF_FFFF, w);
      beat(0, 1'b1, 32'h00, T_NSEQ, 1'b0, 2'd3, 32'h0, w);
      rd(0, 32'h0);
      idle(0, w);
      chk("pin_err_unchanged", rdata0, 32'hCAFE_F00D);

      // move to the two-wait-state slave
      @(negedge clk);
      #1;
      act = 1;
      wr(1, 32'h04, 32'h0BAD_F00D);
      rd(1, 32'h04);
      idle(1, w);
      chk("wait_read_cycles", 32'(w + 1), 32'd3);
      chk("pin_wait_read", rdata1, 32'h0BAD_F00D);

      // reset during the wait phase of a write
      wr(1, 32'h08, 32'h5555_AAAA);
      rd(1, 32'h08);
      idle(1, w);
      chk_en = 1'b0;
      hsel   = 2'b10;
      haddr  = 32'h08;
      htrans = T_NSEQ;
      hwrite = 1'b1;
      hsize  = 2'd2;
      @(posedge clk);
      #1;
      hwdata = 32'shBAD0_BAD0;
      hsel   = 2'b00;
      htrans = T_IDLE;
      chk("wait_ready_low", 32'(rdy1), 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", 32'(rdy1), 32'h1);
      chk("async_rst_resp", 32'(resp1), 32'h0);
      chk("async_rst_rdata", rdata1, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      rd(1, 32'h08);
      idle(1, w);
      chk("pin_rst_old_value", rdata1, 32'h5555_AAAA);

      repeat (3) @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
